// File: rtl/mmio_input_port.sv
// rtl/mmio_input_port.sv - memory-mapped debounced input port with edge flags, event counter and irq
module mmio_input_port #(
  parameter int          WIDTH    = 9,
  parameter logic [31:0] BASE     = 32'h0000_0100,
  parameter int          DEBOUNCE = 16,
  parameter int          CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             hit,
  input  logic [WIDTH-1:0] entradas,
  output logic             irq
);

  // Debounce counters only need to reach DEBOUNCE-1; keep at least one bit.
  localparam int            DW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_EDGE   = 3'd1;
  localparam logic [2:0] OFF_MASK   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CNT    = 3'd4;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [DW-1:0]    dcnt [WIDTH];
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] mask;
  logic [CNTW-1:0]  cnt;

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;
  logic [2:0]       off;
  logic             wr;
  logic             wr_edge;
  logic             wr_mask;
  logic             wr_cnt;
  logic             unused_ok;

  // Byte offset bits and the upper write-data bits carry no meaning here.
  assign unused_ok = &{1'b0, addr[1:0], wd};

  assign hit     = (addr[31:5] == BASE[31:5]);
  assign off     = addr[4:2];
  assign wr      = we & hit;
  assign wr_edge = wr && (off == OFF_EDGE);
  assign wr_mask = wr && (off == OFF_MASK);
  assign wr_cnt  = wr && (off == OFF_CNT);

  assign irq = |(edge_flags & mask);

  // A bit is accepted once it has disagreed with the debounced value for DEBOUNCE edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (dcnt[i] == DLAST);
    end
  end

  // Only accepts toward 1 count as rising edges; falling accepts are silent.
  assign rise = accept & sync2;

  // Two-flop synchronizer for the asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= entradas;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce counters and the accepted (stable) input value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) dcnt[i] <= '0;
    end else begin
      stable <= stable ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == stable[i]) || accept[i]) dcnt[i] <= '0;
        else                                      dcnt[i] <= dcnt[i] + DW'(1);
      end
    end
  end

  // Sticky rise flags; a new rise beats a write-1-to-clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) edge_flags <= '0;
    else     edge_flags <= rise | (edge_flags & ~(wr_edge ? wd[WIDTH-1:0] : '0));
  end

  // Interrupt/count enable mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask <= '0;
    else if (wr_mask) mask <= wd[WIDTH-1:0];
  end

  // Event counter: one count per edge with any enabled rise; a write clears and wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (wr_cnt)         cnt <= '0;
    else if (|(rise & mask)) cnt <= cnt + CNTW'(1);
  end

  // Read mux, purely combinational with no side effects.
  always_comb begin
    rd = '0;
    if (hit) begin
      case (off)
        OFF_DATA:   rd[WIDTH-1:0] = stable;
        OFF_EDGE:   rd[WIDTH-1:0] = edge_flags;
        OFF_MASK:   rd[WIDTH-1:0] = mask;
        OFF_STATUS: rd[1:0]       = {|stable, irq};
        OFF_CNT:    rd[CNTW-1:0]  = cnt;
        default:    rd            = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_input_port.sv
// tb/tb_mmio_input_port.sv - scoreboard bench for mmio_input_port against a windowed reference model
module tb_mmio_input_port;

  localparam int          W    = 9;
  localparam int          D    = 4;
  localparam int          CW   = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wd = '0;
  logic [31:0]   rd;
  logic          hit;
  logic [W-1:0]  entradas = '0;
  logic          irq;

  mmio_input_port #(.WIDTH(W), .BASE(BASE), .DEBOUNCE(D), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .hit(hit), .entradas(entradas), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: an input value is accepted when the last D synchronized
  // samples all disagree with the accepted value.
  logic [W-1:0]  m_stable, m_edge, m_mask, m_rise, m_clr;
  int unsigned   m_cnt;
  logic [W-1:0]  hist[$];
  logic          m_wr, all_ne;

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic m_irq();
    return |(m_edge & m_mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[4:2])
      3'd0: return 32'(m_stable);
      3'd1: return 32'(m_edge);
      3'd2: return 32'(m_mask);
      3'd3: return {30'd0, |m_stable, m_irq()};
      3'd4: return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stable = '0; m_edge = '0; m_mask = '0; m_cnt = 0;
      hist.delete();
      for (int j = 0; j <= D; j++) hist.push_back('0);
    end else begin
      m_rise = '0;
      for (int i = 0; i < W; i++) begin
        all_ne = 1'b1;
        for (int j = 0; j < D; j++) if (hist[j][i] == m_stable[i]) all_ne = 1'b0;
        if (all_ne && !m_stable[i]) m_rise[i] = 1'b1;
        if (all_ne) m_stable[i] = ~m_stable[i];
      end
      m_wr  = we && m_hit(addr);
      m_clr = (m_wr && addr[4:2] == 3'd1) ? wd[W-1:0] : '0;
      m_edge = m_rise | (m_edge & ~m_clr);
      if (m_wr && addr[4:2] == 3'd4)  m_cnt = 0;
      else if (|(m_rise & m_mask))    m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_wr && addr[4:2] == 3'd2)  m_mask = wd[W-1:0];
      hist.push_back(entradas);
      void'(hist.pop_front());
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] rd;
    logic        irq;
    logic        hit;
  } exp_t;

  exp_t         exp_q[$];
  logic         chk_v = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic         rst_v = 1'b1;
  logic [W-1:0] ent_v = '0;

  // Monitor: pops one expectation per presented cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (chk_v) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty: no expectation queued for addr %h", addr);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd || irq !== e.irq || hit !== e.hit) begin
            n_fail++;
            $display("FAIL read_%h: rd=%h irq=%b hit=%b, required rd=%h irq=%b hit=%b (t=%0t)",
                     e.a, rd, irq, hit, e.rd, e.irq, e.hit, $time);
          end
        end
      end
    end
  end

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    rst = rst_v; entradas = ent_v; we = w; addr = a; wd = d;
    #1;
    e.a = a; e.rd = m_read(a); e.irq = m_irq(); e.hit = m_hit(a);
    exp_q.push_back(e);
    chk_v = 1'b1;
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    repeat (n) step(1'b0, a, 32'd0);
  endtask

  task automatic pulse(input int bitn, input int hi, input int lo);
    ent_v[bitn] = 1'b1;
    idle(hi, BASE + 32'h10);
    ent_v[bitn] = 1'b0;
    idle(lo, BASE + 32'h0C);
  endtask

  logic [31:0] ra;

  initial begin
    // Reset, checked while asserted.
    rst_v = 1'b1;
    idle(3, BASE);
    rst_v = 1'b0;

    // Idle register sweep and window boundaries.
    for (int k = 0; k < 8; k++) step(1'b0, BASE + 32'(k * 4), 32'd0);
    step(1'b0, 32'h0000_011F, 32'd0);
    step(1'b0, 32'h0000_0120, 32'd0);
    step(1'b0, 32'h0000_00FF, 32'd0);

    // Clean rise on bit 0 with MASK=0: exact latency, EDGE set, no irq/count.
    ent_v[0] = 1'b1;
    idle(9, BASE);
    step(1'b0, BASE + 32'h04, 32'd0);
    step(1'b0, BASE + 32'h0C, 32'd0);
    step(1'b0, BASE + 32'h10, 32'd0);
    step(1'b1, BASE + 32'h04, 32'h0000_0001);
    ent_v[0] = 1'b0;
    idle(8, BASE);

    // Enable all; upper write bits must be ignored.
    step(1'b1, BASE + 32'h08, 32'hFFFF_FFFF);
    step(1'b0, BASE + 32'h08, 32'd0);
    pulse(4, 3, 8);
    step(1'b0, BASE + 32'h04, 32'd0);
    pulse(4, 4, 8);
    step(1'b0, BASE + 32'h04, 32'd0);

    // Clear on the same edge as a new rise on bit 4: set wins.
    ent_v[4] = 1'b1;
    idle(5, BASE);
    step(1'b1, BASE + 32'h04, 32'h0000_0010);
    step(1'b0, BASE + 32'h04, 32'd0);
    step(1'b1, BASE + 32'h04, 32'h0000_0010);
    step(1'b0, BASE + 32'h0C, 32'd0);
    ent_v[4] = 1'b0;
    idle(8, BASE + 32'h04);

    // Counter wrap, then a clear coincident with an event.
    for (int k = 0; k < (1 << CW) + 1; k++) pulse(2, 5, 6);
    ent_v[2] = 1'b1;
    idle(5, BASE + 32'h10);
    step(1'b1, BASE + 32'h10, 32'd0);
    step(1'b0, BASE + 32'h10, 32'd0);
    ent_v[2] = 1'b0;
    idle(8, BASE + 32'h10);

    // Randomized inputs, accesses and writes.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(5) == 0) ent_v[$urandom_range(W - 1)] ^= 1'b1;
      ra = BASE + 32'($urandom_range(31));
      if ($urandom_range(9) == 0) ra = $urandom_range(1) ? 32'h120 + 32'($urandom_range(63)) : 32'($urandom_range(255));
      if ($urandom_range(7) == 0) step(1'b1, ra, $urandom);
      else                        step(1'b0, ra, $urandom);
    end

    // All inputs high, reset in the middle of debouncing.
    ent_v = '1;
    idle(2, BASE);
    rst_v = 1'b1;
    idle(2, BASE + 32'h04);
    rst_v = 1'b0;
    idle(8, BASE);
    step(1'b0, BASE + 32'h04, 32'd0);
    step(1'b0, BASE + 32'h0C, 32'd0);

    #3;
    chk_v = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
